// File: rtl/efuse_ctrl_nbit.sv
// Serial eFuse controller for CSB/PGM/SCLK fuse macros. It sequences the 2.5 V
// power switch, burns or reads NBITS fuses LSB first, and supports abort.
module efuse_ctrl_nbit #(
    parameter int NBITS      = 32,
    parameter int TCKHP_W    = 4,
    parameter int PWR_SETTLE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [TCKHP_W-1:0] TCKHP,
    input  logic [NBITS-1:0]   prog,
    input  logic               dout,
    output logic               sw_en,
    output logic               sw_rampena,
    output logic               sw_short,
    output logic               CSB,
    output logic               PGM,
    output logic               SCLK,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [NBITS-1:0]   rdata
);

    localparam int BW = $clog2(NBITS);
    localparam int SW = (PWR_SETTLE > 1) ? $clog2(PWR_SETTLE) : 1;
    localparam logic [BW-1:0] BIT_LAST    = BW'(NBITS - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(PWR_SETTLE - 1);
    localparam logic [1:0]    MODE_PROG   = 2'b01;
    localparam logic [1:0]    MODE_READ   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_PWR_EN, S_PWR_RAMP, S_CS_SETUP, S_BIT_HI,
        S_BIT_LO, S_CS_HOLD, S_PWR_RDN, S_PWR_OFF, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic               start_q, start_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic [TCKHP_W-1:0] hi_q, hi_d, hi_last;
    logic               err_q, err_d;
    logic [NBITS-1:0]   rdata_q, rdata_d;
    logic [NBITS-1:0]   prog_q, prog_d;
    logic [NBITS-1:0]   shift_q, shift_d;
    logic [TCKHP_W-1:0] tckhp_q, tckhp_d;
    logic               csb_q, csb_d, pgm_q, pgm_d, sclk_q, sclk_d;
    logic               sw_en_q, sw_en_d, ramp_q, ramp_d, short_q, short_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               is_prog, is_prog_d, in_bits_d;

    assign is_prog = (mode_q == MODE_PROG);

    // Last high-counter value of the current bit: burned bits stretch to TCKHP.
    always_comb begin
        hi_last = '0;
        if (is_prog && prog_q[bit_q] && (tckhp_q != '0)) begin
            hi_last = tckhp_q - TCKHP_W'(1);
        end
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        start_d = start;
        bit_d   = bit_q;
        cnt_d   = '0;
        hi_d    = '0;
        err_d   = err_q;
        rdata_d = rdata_q;
        prog_d  = prog_q;
        tckhp_d = tckhp_q;
        shift_d = shift_q;

        case (state_q)
            S_IDLE: begin
                if (start && !start_q) begin
                    mode_d  = mode;
                    prog_d  = prog;
                    tckhp_d = TCKHP;
                    bit_d   = '0;
                    err_d   = (mode != MODE_PROG) && (mode != MODE_READ);
                    if (mode == MODE_PROG) begin
                        state_d = S_PWR_EN;
                    end else if (mode == MODE_READ) begin
                        state_d = S_CS_SETUP;
                    end
                end
            end
            S_PWR_EN, S_PWR_RAMP, S_PWR_RDN, S_PWR_OFF: begin
                if (cnt_q == SETTLE_LAST) begin
                    case (state_q)
                        S_PWR_EN:   state_d = S_PWR_RAMP;
                        S_PWR_RAMP: state_d = S_CS_SETUP;
                        S_PWR_RDN:  state_d = S_PWR_OFF;
                        default:    state_d = S_DONE;
                    endcase
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            S_CS_SETUP: state_d = S_BIT_HI;
            S_BIT_HI: begin
                if (hi_q == hi_last) begin
                    state_d = S_BIT_LO;
                    if (!is_prog) begin
                        shift_d[bit_q] = dout;
                    end
                end else begin
                    hi_d = hi_q + TCKHP_W'(1);
                end
            end
            S_BIT_LO: begin
                if (bit_q == BIT_LAST) begin
                    bit_d   = '0;
                    state_d = S_CS_HOLD;
                end else begin
                    bit_d   = bit_q + BW'(1);
                    state_d = S_BIT_HI;
                end
            end
            S_CS_HOLD: begin
                if (is_prog) begin
                    state_d = S_PWR_RDN;
                end else begin
                    state_d = S_DONE;
                    rdata_d = shift_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides normal sequencing; an ongoing power-down simply completes.
        if (abort && busy_q) begin
            err_d = 1'b1;
            bit_d = '0;
            hi_d  = '0;
            if (!is_prog) begin
                state_d = S_DONE;
                rdata_d = rdata_q;
            end else if ((state_q != S_PWR_RDN) && (state_q != S_PWR_OFF)) begin
                cnt_d   = '0;
                state_d = ramp_q ? S_PWR_RDN : S_PWR_OFF;
            end
        end
    end

    // Pins are registered from the next state so the fuse macro never sees decode glitches.
    always_comb begin
        is_prog_d = (mode_d == MODE_PROG);
        in_bits_d = (state_d == S_CS_SETUP) || (state_d == S_BIT_HI) || (state_d == S_BIT_LO);
        busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
        csb_d     = !in_bits_d;
        sclk_d    = (state_d == S_BIT_HI);
        pgm_d     = is_prog_d && in_bits_d;
        ramp_d    = is_prog_d && (in_bits_d || (state_d == S_PWR_RAMP) || (state_d == S_CS_HOLD));
        sw_en_d   = is_prog_d && (ramp_d || (state_d == S_PWR_EN) || (state_d == S_PWR_RDN));
        short_d   = !sw_en_d;
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            start_q <= 1'b0;
            bit_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            csb_q   <= 1'b1;
            pgm_q   <= 1'b0;
            sclk_q  <= 1'b0;
            sw_en_q <= 1'b0;
            ramp_q  <= 1'b0;
            short_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            start_q <= start_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            csb_q   <= csb_d;
            pgm_q   <= pgm_d;
            sclk_q  <= sclk_d;
            sw_en_q <= sw_en_d;
            ramp_q  <= ramp_d;
            short_q <= short_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // NOTE: pure datapath registers carry no reset; each is loaded before it is used.
    always_ff @(posedge clk) begin
        prog_q  <= prog_d;
        tckhp_q <= tckhp_d;
        shift_q <= shift_d;
    end

    assign sw_en      = sw_en_q;
    assign sw_rampena = ramp_q;
    assign sw_short   = short_q;
    assign CSB        = csb_q;
    assign PGM        = pgm_q;
    assign SCLK       = sclk_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign rdata      = rdata_q;

endmodule
